// File: rtl/mmu_pkg.sv
// ============================================================================
// Module   : mmu_pkg
// Purpose  : Shared types and constants for the CU memory request responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mmu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_RESP   = 3'd4
    } mmu_state_t;

    localparam logic [3:0] MASK_B0 = 4'b0001;
    localparam logic [3:0] MASK_B1 = 4'b0010;
    localparam logic [3:0] MASK_B2 = 4'b0100;
    localparam logic [3:0] MASK_B3 = 4'b1000;
    localparam logic [3:0] MASK_H0 = 4'b0011;
    localparam logic [3:0] MASK_H1 = 4'b1100;
    localparam logic [3:0] MASK_W  = 4'b1111;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    function automatic logic mask_is_legal(input logic [3:0] mask);
        logic legal;
        legal = 1'b0;
        case (mask)
            MASK_B0, MASK_B1, MASK_B2, MASK_B3,
            MASK_H0, MASK_H1, MASK_W: legal = 1'b1;
            default:                  legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Index of the lowest set lane; 0 when no lane is set.
    function automatic logic [1:0] lowest_lane(input logic [3:0] lanes);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (lanes[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mmu_req_check.sv
// ============================================================================
// Module   : mmu_req_check
// Purpose  : Combinational lane-mask / SRAM-range / alignment validation.
//            Alignment checking is enabled by defining MMU_RESP_ALIGN_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmu_req_check
    import mmu_pkg::*;
#(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] SRAM_BASE = 32'h0000_0000
) (
    input  logic [31:0]       addr,
    input  logic [3:0]        mask,
    output logic [ADDR_W-3:0] word_addr,
    output logic              fault
);

    logic [31:0] w_offset;
    logic        w_mask_bad;
    logic        w_range_bad;
    logic        w_align_bad;
    logic        w_unused_low;

    // A wrapped subtraction lands in the upper bits and so reads as out of range.
    assign w_offset     = addr - SRAM_BASE;
    assign w_mask_bad   = !mask_is_legal(mask);
    assign w_range_bad  = |w_offset[31:ADDR_W];
    assign word_addr    = w_offset[ADDR_W-1:2];
    assign w_unused_low = ^w_offset[1:0];

`ifdef MMU_RESP_ALIGN_CHECK_EN
    assign w_align_bad = |addr[1:0];
`else
    assign w_align_bad = 1'b0;
`endif

    assign fault = w_mask_bad | w_range_bad | w_align_bad;

endmodule

`default_nettype wire

// File: rtl/mmu_if_responder.sv
// ============================================================================
// Module   : mmu_if_responder
// Purpose  : CU memory request responder; serialises one request per lane onto
//            a byte-wide SRAM and returns a lane-positioned word.
//            Optional alignment fault: MMU_RESP_ALIGN_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmu_if_responder
    import mmu_pkg::*;
#(
    parameter int          ADDR_W    = 12,
    parameter logic [31:0] SRAM_BASE = 32'h0000_0000
) (
    input  logic              soc_clk,
    input  logic              IF_reset_reg,
    input  logic              memfetch_start,
    input  logic [31:0]       addr,
    input  logic [3:0]        bits_to_access,
    input  logic              read_or_write,
    input  logic [31:0]       wdata,
    output logic              mem_busy,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic              resp_fault,
    output logic              sram_cs,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_wdata,
    input  logic [7:0]        sram_rdata
);

    mmu_state_t        r_state;
    mmu_state_t        w_next_state;

    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_lanes;
    logic              r_rw;
    logic              r_cap_pend;
    logic [1:0]        r_cap_lane;

    logic              w_accept;
    logic              w_issue;
    logic              w_fault;
    logic [1:0]        w_lane;
    logic [ADDR_W-3:0] w_word_addr;

    mmu_req_check #(
        .ADDR_W    (ADDR_W),
        .SRAM_BASE (SRAM_BASE)
    ) u_req_check (
        .addr      (r_addr),
        .mask      (r_lanes),
        .word_addr (w_word_addr),
        .fault     (w_fault)
    );

    assign w_accept   = (r_state == ST_IDLE) && memfetch_start;
    assign w_lane     = lowest_lane(r_lanes);
    assign mem_busy   = (r_state != ST_IDLE);
    assign resp_valid = (r_state == ST_RESP);

    always_ff @(posedge soc_clk or posedge IF_reset_reg) begin
        if (IF_reset_reg) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // r_lanes holds the lanes not yet issued; the sequencer always takes the lowest.
    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (memfetch_start) w_next_state = ST_CHECK;
            end
            ST_CHECK: begin
                if (w_fault) begin
                    w_next_state = ST_RESP;
                end else begin
                    w_next_state = ST_ACCESS;
                    w_issue      = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (r_lanes == 4'b0000) begin
                    w_next_state = ST_DRAIN;
                end else begin
                    w_issue = 1'b1;
                end
            end
            ST_DRAIN: w_next_state = ST_RESP;
            ST_RESP:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge soc_clk or posedge IF_reset_reg) begin
        if (IF_reset_reg) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_lanes    <= '0;
            r_rw       <= RW_READ;
            resp_data  <= '0;
            resp_fault <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr     <= addr;
                r_wdata    <= wdata;
                r_lanes    <= bits_to_access;
                r_rw       <= read_or_write;
                resp_data  <= '0;
                resp_fault <= 1'b0;
            end else begin
                if (r_state == ST_CHECK) resp_fault <= w_fault;
                if (w_issue) r_lanes[w_lane] <= 1'b0;
                if (r_cap_pend) resp_data[{r_cap_lane, 3'b000} +: 8] <= sram_rdata;
            end
        end
    end

    // Read data returns one cycle after its strobe, so remember which lane it belongs to.
    always_ff @(posedge soc_clk or posedge IF_reset_reg) begin
        if (IF_reset_reg) begin
            sram_cs    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            r_cap_pend <= 1'b0;
            r_cap_lane <= 2'd0;
        end else begin
            r_cap_pend <= sram_cs && (sram_we == RW_READ);
            r_cap_lane <= sram_addr[1:0];
            if (w_issue) begin
                sram_cs    <= 1'b1;
                sram_we    <= r_rw;
                sram_addr  <= {w_word_addr, w_lane};
                sram_wdata <= r_wdata[{w_lane, 3'b000} +: 8];
            end else begin
                sram_cs <= 1'b0;
                sram_we <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mmu_if_responder.sv
// ============================================================================
// Module   : tb_mmu_if_responder
// Purpose  : Directed self-checking bench for mmu_if_responder with an SRAM model.
//            Alignment expectations follow MMU_RESP_ALIGN_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mmu_if_responder;

    localparam int ADDR_W = 12;

    logic              soc_clk = 1'b0;
    logic              IF_reset_reg = 1'b1;
    logic              memfetch_start = 1'b0;
    logic [31:0]       addr = '0;
    logic [3:0]        bits_to_access = '0;
    logic              read_or_write = 1'b0;
    logic [31:0]       wdata = '0;
    logic              mem_busy;
    logic              resp_valid;
    logic [31:0]       resp_data;
    logic              resp_fault;
    logic              sram_cs;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [7:0]        sram_wdata;
    logic [7:0]        sram_rdata;

    logic [7:0]        mem [0:(1<<ADDR_W)-1];

    int                n_vec = 0;
    int                n_err = 0;
    int                st_total = 0;
    int                resp_total = 0;
    logic              st_we   [0:63];
    logic [ADDR_W-1:0] st_addr [0:63];
    logic [7:0]        st_data [0:63];

    mmu_if_responder #(
        .ADDR_W    (ADDR_W),
        .SRAM_BASE (32'h0000_0000)
    ) dut (
        .soc_clk        (soc_clk),
        .IF_reset_reg   (IF_reset_reg),
        .memfetch_start (memfetch_start),
        .addr           (addr),
        .bits_to_access (bits_to_access),
        .read_or_write  (read_or_write),
        .wdata          (wdata),
        .mem_busy       (mem_busy),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .resp_fault     (resp_fault),
        .sram_cs        (sram_cs),
        .sram_we        (sram_we),
        .sram_addr      (sram_addr),
        .sram_wdata     (sram_wdata),
        .sram_rdata     (sram_rdata)
    );

    always #5 soc_clk = ~soc_clk;

    // Byte SRAM with registered read; test pattern loaded while reset is held.
    always @(posedge soc_clk) begin
        if (IF_reset_reg) begin
            mem[12'h010] <= 8'h11;
            mem[12'h011] <= 8'h22;
            mem[12'h012] <= 8'h33;
            mem[12'h013] <= 8'h44;
            sram_rdata   <= 8'h00;
        end else if (sram_cs) begin
            if (sram_we) mem[sram_addr] <= sram_wdata;
            else         sram_rdata     <= mem[sram_addr];
        end
    end

    always @(negedge soc_clk) begin
        if (sram_cs === 1'b1) begin
            st_we[st_total % 64]   = sram_we;
            st_addr[st_total % 64] = sram_addr;
            st_data[st_total % 64] = sram_wdata;
            st_total++;
        end
        if (resp_valid === 1'b1) resp_total++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // lat counts rising edges from the accept edge up to the one that raises resp_valid.
    task automatic run_req(input logic [31:0] a, input logic [3:0] m, input logic w,
                           input logic [31:0] d, output int lat, output logic [31:0] data,
                           output logic flt, output int sbase);
        @(negedge soc_clk);
        sbase          = st_total;
        memfetch_start = 1'b1;
        addr           = a;
        bits_to_access = m;
        read_or_write  = w;
        wdata          = d;
        @(posedge soc_clk);
        lat = 1;
        @(negedge soc_clk);
        memfetch_start = 1'b0;
        while (resp_valid !== 1'b1 && lat < 30) begin
            @(posedge soc_clk);
            lat++;
            @(negedge soc_clk);
        end
        data = resp_data;
        flt  = resp_fault;
    endtask

    initial begin
        int          lat;
        int          sb;
        int          rb;
        int          k;
        logic [31:0] data;
        logic        flt;

        repeat (2) @(negedge soc_clk);
        chk("rst_busy",  32'(mem_busy),   32'd0);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_fault", 32'(resp_fault), 32'd0);
        chk("rst_cs",    32'(sram_cs),    32'd0);
        chk("rst_we",    32'(sram_we),    32'd0);
        chk("rst_data",  resp_data,       32'd0);
        chk("rst_saddr", 32'(sram_addr),  32'd0);
        chk("rst_swdat", 32'(sram_wdata), 32'd0);
        IF_reset_reg = 1'b0;
        @(negedge soc_clk);

        run_req(32'h10, 4'b1111, 1'b0, 32'h0, lat, data, flt, sb);
        chk("rdw_lat",   32'(lat), 32'd7);
        chk("rdw_data",  data, 32'h4433_2211);
        chk("rdw_fault", 32'(flt), 32'd0);
        chk("rdw_nstb",  32'(st_total - sb), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("rdw_saddr", 32'(st_addr[(sb + i) % 64]), 32'h10 + 32'(i));
            chk("rdw_swe",   32'(st_we[(sb + i) % 64]),   32'd0);
        end
        @(negedge soc_clk);
        chk("rdw_pulse", 32'(resp_valid), 32'd0);
        chk("rdw_idle",  32'(mem_busy),   32'd0);

        run_req(32'h20, 4'b1100, 1'b1, 32'hAABB_CCDD, lat, data, flt, sb);
        chk("wrh_lat",   32'(lat), 32'd5);
        chk("wrh_data",  data, 32'd0);
        chk("wrh_fault", 32'(flt), 32'd0);
        chk("wrh_nstb",  32'(st_total - sb), 32'd2);
        chk("wrh_a0",    32'(st_addr[sb % 64]),       32'h22);
        chk("wrh_d0",    32'(st_data[sb % 64]),       32'hBB);
        chk("wrh_we0",   32'(st_we[sb % 64]),         32'd1);
        chk("wrh_a1",    32'(st_addr[(sb + 1) % 64]), 32'h23);
        chk("wrh_d1",    32'(st_data[(sb + 1) % 64]), 32'hAA);
        chk("wrh_mem",   {16'h0, mem[12'h023], mem[12'h022]}, 32'h0000_AABB);

        run_req(32'h20, 4'b1100, 1'b0, 32'h0, lat, data, flt, sb);
        chk("rdh_lat",  32'(lat), 32'd5);
        chk("rdh_data", data, 32'hAABB_0000);
        repeat (2) @(negedge soc_clk);
        chk("rdh_keep", resp_data, 32'hAABB_0000);

        run_req(32'h10, 4'b0100, 1'b0, 32'h0, lat, data, flt, sb);
        chk("rdb_lat",  32'(lat), 32'd4);
        chk("rdb_data", data, 32'h0033_0000);
        chk("rdb_addr", 32'(st_addr[sb % 64]), 32'h12);

        run_req(32'h10, 4'b0101, 1'b0, 32'h0, lat, data, flt, sb);
        chk("msk_lat",   32'(lat), 32'd2);
        chk("msk_fault", 32'(flt), 32'd1);
        chk("msk_data",  data, 32'd0);
        chk("msk_nstb",  32'(st_total - sb), 32'd0);

        run_req(32'h10, 4'b0000, 1'b0, 32'h0, lat, data, flt, sb);
        chk("msk0_fault", 32'(flt), 32'd1);

        run_req(32'h1000, 4'b1111, 1'b0, 32'h0, lat, data, flt, sb);
        chk("rng_lat",   32'(lat), 32'd2);
        chk("rng_fault", 32'(flt), 32'd1);
        chk("rng_nstb",  32'(st_total - sb), 32'd0);

        run_req(32'h11, 4'b0001, 1'b0, 32'h0, lat, data, flt, sb);
`ifdef MMU_RESP_ALIGN_CHECK_EN
        chk("aln_lat",   32'(lat), 32'd2);
        chk("aln_fault", 32'(flt), 32'd1);
        chk("aln_nstb",  32'(st_total - sb), 32'd0);
`else
        chk("aln_lat",   32'(lat), 32'd4);
        chk("aln_fault", 32'(flt), 32'd0);
        chk("aln_data",  data, 32'h0000_0011);
        chk("aln_addr",  32'(st_addr[sb % 64]), 32'h10);
`endif

        // Start strobes while busy and during RESP must be dropped.
        @(negedge soc_clk);
        #1;
        rb = resp_total;
        sb = st_total;
        memfetch_start = 1'b1;
        addr           = 32'h10;
        bits_to_access = 4'b1111;
        read_or_write  = 1'b0;
        @(negedge soc_clk);
        addr           = 32'h30;
        bits_to_access = 4'b0011;
        read_or_write  = 1'b1;
        wdata          = 32'h1234_5678;
        repeat (3) @(negedge soc_clk);
        memfetch_start = 1'b0;
        k = 0;
        while (resp_valid !== 1'b1 && k < 30) begin
            @(negedge soc_clk);
            k++;
        end
        chk("bsy_resp", 32'(resp_valid), 32'd1);
        memfetch_start = 1'b1;
        @(negedge soc_clk);
        memfetch_start = 1'b0;
        chk("bsy_drop", 32'(mem_busy), 32'd0);
        chk("bsy_data", resp_data, 32'h4433_2211);
        repeat (4) @(negedge soc_clk);
        #1;
        chk("bsy_nresp", 32'(resp_total - rb), 32'd1);
        chk("bsy_nstb",  32'(st_total - sb),   32'd4);

        // Asynchronous reset in the middle of ACCESS.
        @(negedge soc_clk);
        memfetch_start = 1'b1;
        addr           = 32'h10;
        bits_to_access = 4'b1111;
        read_or_write  = 1'b0;
        @(negedge soc_clk);
        memfetch_start = 1'b0;
        @(negedge soc_clk);
        chk("rsa_cs_on", 32'(sram_cs), 32'd1);
        #1;
        rb = resp_total;
        #1 IF_reset_reg = 1'b1;
        #1;
        chk("rsa_cs_off", 32'(sram_cs),  32'd0);
        chk("rsa_busy",   32'(mem_busy), 32'd0);
        @(negedge soc_clk);
        IF_reset_reg = 1'b0;
        repeat (10) @(negedge soc_clk);
        #1;
        chk("rsa_noresp", 32'(resp_total - rb), 32'd0);

        run_req(32'h10, 4'b1111, 1'b0, 32'h0, lat, data, flt, sb);
        chk("rsa_lat",   32'(lat), 32'd7);
        chk("rsa_data",  data, 32'h4433_2211);
        chk("rsa_fault", 32'(flt), 32'd0);

        repeat (2) @(negedge soc_clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mmu_if_responder.md
# mmu_if_responder

Memory-side responder for control-unit fetch and load/store requests. Accepts one request at a time (start strobe, word address, byte-lane mask, read/write flag), validates it, and serialises it onto a byte-wide single-port SRAM one lane per cycle. Reassembles read bytes into a lane-positioned 32-bit word and returns it with a one-cycle response pulse and fault flag. Sits between the CU stage logic and on-chip SRAM, as the responder end of the CU memory request interface.

## Interface
Parameters:
- ADDR_W, 12, SRAM byte-address width (SRAM size 2^ADDR_W bytes)
- SRAM_BASE, 32'h0000_0000, CU address mapped to SRAM byte 0

Ports:
- soc_clk  in  1  clock; all logic on rising edge
- IF_reset_reg  in  1  reset, asynchronous, active-high
- memfetch_start  in  1  request strobe, sampled only in IDLE
- addr  in  32  request byte address (word address with low bits 00)
- bits_to_access  in  4  byte-lane enable, bit i = byte lane i
- read_or_write  in  1  0 = read, 1 = write
- wdata  in  32  write data, lane-positioned
- mem_busy  out  1  request in progress
- resp_valid  out  1  one-cycle response pulse
- resp_data  out  32  read data, lane-positioned; disabled lanes 0
- resp_fault  out  1  request rejected; valid only with resp_valid
- sram_cs  out  1  SRAM byte access strobe
- sram_we  out  1  SRAM write enable (qualified by sram_cs)
- sram_addr  out  ADDR_W  SRAM byte address
- sram_wdata  out  8  SRAM write byte
- sram_rdata  in  8  SRAM read byte, valid the cycle after a read strobe

## Operation
- States: IDLE, CHECK, ACCESS, DRAIN, RESP.
- IDLE: memfetch_start=1 latches addr, bits_to_access, read_or_write, wdata; next CHECK. Inputs are not used after latch.
- CHECK: fault if mask not in {0001,0010,0100,1000,0011,1100,1111}; fault if (addr - SRAM_BASE) >= 2^ADDR_W (32-bit unsigned subtract, wrap counts as out of range); alignment fault per Configuration. Fault -> RESP with resp_fault=1, resp_data=0, no SRAM strobe. Else -> ACCESS.
- ACCESS: one cycle per enabled lane, ascending lane order, disabled lanes skipped (no cycle). Each cycle: sram_cs=1, sram_we=read_or_write, sram_addr = (addr - SRAM_BASE)[ADDR_W-1:2] concatenated with lane, sram_wdata = wdata byte for lane. After last enabled lane -> DRAIN.
- Read capture: sram_rdata written into resp_data byte of the lane issued in the previous cycle (captures in ACCESS and DRAIN).
- DRAIN: no strobe; final capture; -> RESP. Also used for writes (uniform latency).
- RESP: resp_valid=1 for one cycle, resp_data/resp_fault held; -> IDLE. Writes return resp_data=0.
- mem_busy=1 in CHECK, ACCESS, DRAIN, RESP; memfetch_start ignored in those states (no queueing). Start during RESP dropped.
- resp_data cleared on accept; retained after RESP until the next accept.

## Timing
- Accept at edge T (IDLE, start=1). CHECK cycle T+1; ACCESS T+2..T+1+n (n = enabled lanes); DRAIN T+2+n; resp_valid T+3+n.
- Word (n=4): 7 cycles start to response; byte: 4; fault: resp_valid at T+2.
- Back-to-back: earliest next accept is the IDLE cycle after RESP.
- Reset values: mem_busy, resp_valid, resp_fault, sram_cs, sram_we = 0; resp_data, sram_addr, sram_wdata = 0; state IDLE.
- Reset mid-operation: immediate return to IDLE, SRAM strobe deasserted asynchronously, request dropped, no response emitted.
- SRAM outputs are registered; sram_cs never high outside ACCESS.

## Configuration
- MMU_RESP_ALIGN_CHECK_EN defined: addr[1:0] != 00 -> fault in CHECK.
- Undefined: addr[1:0] ignored (treated as 00); no alignment fault.

## Structure
- Package mmu_pkg: state enum, legal-mask constants, read/write encoding constants (RW_READ=0, RW_WRITE=1).
- Sub-module mmu_req_check: combinational mask/range/alignment check returning fault; instantiated in CHECK path. FSM, lane sequencer, and capture stay in mmu_if_responder.

## Test plan
- Read word: SRAM bytes 0x10..0x13 = 11,22,33,44; start, addr=0x10, mask=1111, read -> four strobes at 0x10..0x13, resp_valid 7 cycles after start, resp_data=0x44332211, fault=0.
- Write halfword: addr=0x20, mask=1100, wdata=0xAABBCCDD -> two strobes, we=1, bytes BB@0x22 then AA@0x23, resp_valid 5 cycles after start, resp_data=0.
- Illegal mask 0101 or addr=SRAM_BASE+0x1000 (ADDR_W=12) -> no sram_cs, resp_valid at T+2 with resp_fault=1.
- Alignment: addr=0x11, mask=0001 -> fault with MMU_RESP_ALIGN_CHECK_EN; without it, read of byte 0x10.
- Start pulses while mem_busy=1 -> ignored, exactly one response.
- Reset asserted during ACCESS -> sram_cs drops immediately, no resp_valid; new read after release completes normally.
